debug_uart_tx: RTL and testbench

//  Host-side end of the CPU debug-port link: snapshots the seven 8-bit debug

---
 rtl/debug_uart_tx_if.sv | 31 +++
 rtl/debug_uart_tx.sv | 146 ++++++++++++++
 tb/tb_debug_uart_tx.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/debug_uart_tx_if.sv
// Signal bundle between a debug-port producer and debug_uart_tx.
// Carries the frame request, the seven payload bytes and the UART status.
interface debug_uart_tx_if;
  logic       start;
  logic [7:0] debug_port1;
  logic [7:0] debug_port2;
  logic [7:0] debug_port3;
  logic [7:0] debug_port4;
  logic [7:0] debug_port5;
  logic [7:0] debug_port6;
  logic [7:0] debug_port7;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output start,
    output debug_port1, debug_port2, debug_port3,
    output debug_port4, debug_port5, debug_port6,
    output debug_port7,
    input  tx, busy, done
  );

  modport slave (
    input  start,
    input  debug_port1, debug_port2, debug_port3,
    input  debug_port4, debug_port5, debug_port6,
    input  debug_port7,
    output tx, busy, done
  );
endinterface

// File: rtl/debug_uart_tx.sv
// Snapshots seven debug ports and sends them as one 8N1 UART frame.
// Define DEBUG_TX_CHECKSUM_EN to append an XOR checksum byte.
module debug_uart_tx #(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
  input logic           clk,
  input logic           nreset,
  debug_uart_tx_if.slave bus
);
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NBYTES = 9;
`else
  localparam int NBYTES = 8;
`endif
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(NBYTES);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BYTE_LAST = BW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_d;
  logic [BW-1:0] byte_idx, byte_d;
  logic          tx, tx_d;
  logic          busy, busy_d;
  logic          done, done_d;
  logic          load;
  logic [7:0]    snap [NBYTES];
  logic [7:0]    cur;
  logic [2:0]    nbit;
  logic          last;

  assign bus.tx   = tx;
  assign bus.busy = busy;
  assign bus.done = done;

  assign cur  = snap[byte_idx];
  assign nbit = bit_idx + 3'd1;
  assign last = (cnt == CNT_LAST);

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    bit_d   = bit_idx;
    byte_d  = byte_idx;
    tx_d    = tx;
    busy_d  = busy;
    done_d  = 1'b0;
    load    = 1'b0;
    if (state != IDLE)
      cnt_d = last ? '0 : cnt + CW'(1);
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = START;
          cnt_d   = '0;
          bit_d   = '0;
          byte_d  = '0;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
        end
      end
      START: begin
        if (last) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = cur[0];
        end
      end
      DATA: begin
        if (last) begin
          if (bit_idx == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = nbit;
            tx_d  = cur[nbit];
          end
        end
      end
      STOP: begin
        if (last) begin
          if (byte_idx == BYTE_LAST) begin
            state_d = IDLE;
            byte_d  = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            byte_d  = byte_idx + BW'(1);
            tx_d    = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state    <= IDLE;
      cnt      <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      bit_idx  <= bit_d;
      byte_idx <= byte_d;
      tx       <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < NBYTES; i++)
        snap[i] <= '0;
    end else if (load) begin
      snap[0] <= SYNC_BYTE;
      snap[1] <= bus.debug_port1;
      snap[2] <= bus.debug_port2;
      snap[3] <= bus.debug_port3;
      snap[4] <= bus.debug_port4;
      snap[5] <= bus.debug_port5;
      snap[6] <= bus.debug_port6;
      snap[7] <= bus.debug_port7;
`ifdef DEBUG_TX_CHECKSUM_EN
      snap[8] <= bus.debug_port1 ^ bus.debug_port2
               ^ bus.debug_port3 ^ bus.debug_port4
               ^ bus.debug_port5 ^ bus.debug_port6
               ^ bus.debug_port7;
`endif
    end
  end
endmodule

// File: tb/tb_debug_uart_tx.sv
// Randomised bench for debug_uart_tx with a byte-level frame model.
// Every cycle of each frame is checked against the expected line state.
module tb_debug_uart_tx;
  localparam int C = 4;
`ifdef DEBUG_TX_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif
  localparam int L = NB * 10 * C;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic [7:0] frame [NB];
  logic [7:0] p [7];
  logic [7:0] q [7];

  always #5 clk = ~clk;

  debug_uart_tx_if bus ();

  debug_uart_tx #(.CLKS_PER_BIT(C), .SYNC_BYTE(8'hA5)) dut (
    .clk(clk),
    .nreset(nreset),
    .bus(bus.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] v [7]);
    bus.debug_port1 = v[0];
    bus.debug_port2 = v[1];
    bus.debug_port3 = v[2];
    bus.debug_port4 = v[3];
    bus.debug_port5 = v[4];
    bus.debug_port6 = v[5];
    bus.debug_port7 = v[6];
  endtask

  // Frame bit k: byte k/10, position 0 = start, 1..8 = data LSB first, 9 = stop
  function automatic logic exp_bit(input int k);
    int b = k / 10;
    int pos = k % 10;
    if (pos == 0) return 1'b0;
    if (pos == 9) return 1'b1;
    return frame[b][pos-1];
  endfunction

  task automatic start_frame(input logic [7:0] v [7]);
    logic [7:0] x = 8'h00;
    drive(v);
    frame[0] = 8'hA5;
    for (int i = 0; i < 7; i++) begin
      frame[i+1] = v[i];
      x ^= v[i];
    end
`ifdef DEBUG_TX_CHECKSUM_EN
    frame[8] = x;
`endif
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // mode 0 plain, 1 ports change, 2 spurious starts, 3 reset at 150
  task automatic watch_frame(input int mode);
    logic [7:0] ff [7];
    for (int i = 0; i < 7; i++) ff[i] = 8'hFF;
    for (int j = 0; j < L; j++) begin
      if (mode == 3 && j == 150) begin
        nreset = 1'b0;
        #1;
        chk("abort_tx", bus.tx, 1);
        chk("abort_busy", bus.busy, 0);
        chk("abort_done", bus.done, 0);
        repeat (3) begin
          tick();
          chk("rst_hold_tx", bus.tx, 1);
          chk("rst_hold_done", bus.done, 0);
        end
        nreset = 1'b1;
        tick();
        chk("post_rst_busy", bus.busy, 0);
        chk("post_rst_tx", bus.tx, 1);
        return;
      end
      chk($sformatf("tx_%0d", j), bus.tx, exp_bit(j / C));
      chk("busy_in_frame", bus.busy, 1);
      chk("done_early", bus.done, 0);
      if (mode == 1 && j == 1) drive(ff);
      if (mode == 2 && (j == 10 || j == 100)) bus.start = 1'b1;
      if (mode == 2 && (j == 11 || j == 101)) bus.start = 1'b0;
      tick();
    end
    chk("done_pulse", bus.done, 1);
    chk("busy_end", bus.busy, 0);
    chk("tx_end", bus.tx, 1);
  endtask

  task automatic after_done();
    tick();
    chk("done_one_cycle", bus.done, 0);
    chk("idle_busy", bus.busy, 0);
    chk("idle_tx", bus.tx, 1);
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 7; i++) p[i] = 8'h00;
    drive(p);
    repeat (5) begin
      tick();
      chk("rst_tx", bus.tx, 1);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
    end
    nreset = 1'b1;
    tick();
    chk("idle_tx0", bus.tx, 1);

    for (int i = 0; i < 7; i++) p[i] = 8'(i + 1);
    start_frame(p);
    watch_frame(0);
    after_done();

    start_frame(p);
    watch_frame(1);
    after_done();

    start_frame(p);
    watch_frame(2);
    after_done();

    start_frame(p);
    watch_frame(0);
    q = '{8'h10, 8'h20, 8'h40, 8'h80, 8'h00, 8'h00, 8'h01};
    start_frame(q);
    watch_frame(0);
    after_done();

    start_frame(p);
    watch_frame(3);
    start_frame(p);
    watch_frame(0);
    after_done();

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 7; i++) p[i] = 8'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      start_frame(p);
      watch_frame(r == 2 ? 2 : 0);
      if (r == 1) begin
        for (int i = 0; i < 7; i++) p[i] = 8'($urandom);
        start_frame(p);
        watch_frame(0);
      end
      after_done();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
